// File: rtl/triangle_raster_scheduler.sv
// Two-requester round-robin scheduler that hands triangles to a rasterizer
// timing unit and tracks per-triangle pixel counts and timeouts.
package triangle_raster_pkg;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } Vector4_t;
endpackage

module triangle_raster_scheduler
  import triangle_raster_pkg::*;
#(
  parameter int COUNT_W       = 32,
  parameter int START_TIMEOUT = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid0,
  input  logic               i_valid1,
  output logic               o_ready0,
  output logic               o_ready1,
  input  Vector4_t           i_v1_0,
  input  Vector4_t           i_v2_0,
  input  Vector4_t           i_v3_0,
  input  Vector4_t           i_v1_1,
  input  Vector4_t           i_v2_1,
  input  Vector4_t           i_v3_1,
  output Vector4_t           o_v1,
  output Vector4_t           o_v2,
  output Vector4_t           o_v3,
  output logic               o_start,
  input  logic               i_rast_idle,
  input  logic               i_rast_valid,
  output logic               o_busy,
  output logic               o_owner,
  output logic               o_done,
  output logic               o_error,
  output logic [COUNT_W-1:0] o_pixel_count,
  output logic [15:0]        o_tri_count
);

  localparam int TMO_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;
  Vector4_t           v1_q, v1_d;
  Vector4_t           v2_q, v2_d;
  Vector4_t           v3_q, v3_d;
  logic [COUNT_W-1:0] pix_q, pix_d;
  logic [COUNT_W-1:0] run_q, run_d;
  logic [COUNT_W-1:0] run_inc;
  logic [15:0]        tri_q, tri_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic gnt1;
  logic in_idle;
  logic accept;

  // Grant: requester 1 wins alone, or on contention when the pointer favours it.
  always_comb begin
    gnt1     = i_valid1 & (~i_valid0 | ptr_q);
    in_idle  = (state_q == S_IDLE) & i_reset_n;
    o_ready0 = in_idle & i_valid0 & ~gnt1;
    o_ready1 = in_idle & i_valid1 & gnt1;
    accept   = o_ready0 | o_ready1;
    run_inc  = (&run_q) ? run_q : run_q + COUNT_W'(1);
  end

  // Next-state and datapath updates for the scheduling sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    pix_d   = pix_q;
    run_d   = run_q;
    tri_d   = tri_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          v1_d    = gnt1 ? i_v1_1 : i_v1_0;
          v2_d    = gnt1 ? i_v2_1 : i_v2_0;
          v3_d    = gnt1 ? i_v3_1 : i_v3_0;
          owner_d = gnt1;
          ptr_d   = ~gnt1;
          run_d   = '0;
          tmo_d   = '0;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_rast_valid) run_d = run_inc;
        if (!i_rast_idle) begin
          state_d = S_WAIT_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (i_rast_valid) run_d = run_inc;
        if (i_rast_idle) begin
          pix_d   = run_d;
          tri_d   = tri_q + 16'd1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      pix_q   <= '0;
      run_q   <= '0;
      tri_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      start_q <= start_d;
      done_q  <= done_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      pix_q   <= pix_d;
      run_q   <= run_d;
      tri_q   <= tri_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_v1          = v1_q;
  assign o_v2          = v2_q;
  assign o_v3          = v3_q;
  assign o_start       = start_q;
  assign o_busy        = busy_q;
  assign o_owner       = owner_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_pixel_count = pix_q;
  assign o_tri_count   = tri_q;

endmodule

// File: tb/tb_triangle_raster_scheduler.sv
// Bench for triangle_raster_scheduler: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_triangle_raster_scheduler;
  import triangle_raster_pkg::*;

  localparam int CW  = 32;
  localparam int TMO = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_valid0 = 1'b0, i_valid1 = 1'b0;
  logic          o_ready0, o_ready1;
  Vector4_t      i_v1_0 = '0, i_v2_0 = '0, i_v3_0 = '0;
  Vector4_t      i_v1_1 = '0, i_v2_1 = '0, i_v3_1 = '0;
  Vector4_t      o_v1, o_v2, o_v3;
  logic          o_start;
  logic          i_rast_idle, i_rast_valid;
  logic          o_busy, o_owner, o_done, o_error;
  logic [CW-1:0] o_pixel_count;
  logic [15:0]   o_tri_count;

  triangle_raster_scheduler #(.COUNT_W(CW), .START_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_valid0(i_valid0), .i_valid1(i_valid1),
    .o_ready0(o_ready0), .o_ready1(o_ready1),
    .i_v1_0(i_v1_0), .i_v2_0(i_v2_0), .i_v3_0(i_v3_0),
    .i_v1_1(i_v1_1), .i_v2_1(i_v2_1), .i_v3_1(i_v3_1),
    .o_v1(o_v1), .o_v2(o_v2), .o_v3(o_v3),
    .o_start(o_start),
    .i_rast_idle(i_rast_idle), .i_rast_valid(i_rast_valid),
    .o_busy(o_busy), .o_owner(o_owner),
    .o_done(o_done), .o_error(o_error),
    .o_pixel_count(o_pixel_count), .o_tri_count(o_tri_count)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int exp_tri = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // A triangle covers its bounding box, one pixel per covered cell.
  function automatic int area(Vector4_t a, Vector4_t b, Vector4_t c);
    int x0, x1, y0, y1;
    x0 = imin(int'(a.x), imin(int'(b.x), int'(c.x)));
    x1 = imax(int'(a.x), imax(int'(b.x), int'(c.x)));
    y0 = imin(int'(a.y), imin(int'(b.y), int'(c.y)));
    y1 = imax(int'(a.y), imax(int'(b.y), int'(c.y)));
    return (x1 - x0 + 1) * (y1 - y0 + 1);
  endfunction

  function automatic Vector4_t mkv(int x, int y);
    Vector4_t v;
    v.x = 32'(x);
    v.y = 32'(y);
    v.z = 32'h0;
    v.w = 32'h1;
    return v;
  endfunction

  // Rasterizer stand-in: on start, goes busy and emits one valid per pixel.
  bit rast_en = 1'b1;
  int rem;
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      i_rast_idle  <= 1'b1;
      i_rast_valid <= 1'b0;
      rem          <= 0;
    end else if (!rast_en) begin
      i_rast_idle  <= 1'b1;
      i_rast_valid <= 1'b0;
      rem          <= 0;
    end else if (o_start) begin
      rem          <= area(o_v1, o_v2, o_v3) - 1;
      i_rast_idle  <= 1'b0;
      i_rast_valid <= 1'b1;
    end else if (rem > 0) begin
      rem <= rem - 1;
    end else begin
      i_rast_idle  <= 1'b1;
      i_rast_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit r, input Vector4_t a, input Vector4_t b,
                         input Vector4_t c, input bit v);
    if (r) begin
      i_v1_1 = a; i_v2_1 = b; i_v3_1 = c; i_valid1 = v;
    end else begin
      i_v1_0 = a; i_v2_0 = b; i_v3_0 = c; i_valid0 = v;
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    exp_tri = 0;
  endtask

  // Offer one triangle and hold until accepted; returns at the accept edge.
  task automatic offer(input bit r, input Vector4_t a, input Vector4_t b,
                       input Vector4_t c);
    int n;
    @(negedge i_clk);
    set_req(r, a, b, c, 1'b1);
    #1;
    n = 0;
    while (!(r ? o_ready1 : o_ready0) && n < 50) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    chk("ready_seen", 128'(r ? o_ready1 : o_ready0), 128'd1);
    @(posedge i_clk);
    #1;
    set_req(r, a, b, c, 1'b0);
  endtask

  task automatic run_one(input bit r, input Vector4_t a, input Vector4_t b,
                         input Vector4_t c, input int exp_pix);
    int dones;
    offer(r, a, b, c);
    @(negedge i_clk);
    chk("start_lat", 128'(o_start), 128'd1);
    chk("owner", 128'(o_owner), 128'(r));
    chk("v1_latch", 128'(o_v1), 128'(a));
    @(negedge i_clk);
    chk("start_once", 128'(o_start), 128'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    exp_tri++;
    chk("done_once", 128'(dones), 128'd1);
    chk("pix_count", 128'(o_pixel_count), 128'(exp_pix));
    chk("tri_count", 128'(o_tri_count), 128'(exp_tri));
    chk("idle_after", 128'(o_busy), 128'd0);
  endtask

  typedef struct {
    bit req;
    int x1, y1, x2, y2, x3, y3;
    int pix;
  } row_t;

  row_t tbl[5];

  initial begin
    bit             off_valid[2];
    Vector4_t       off_v[2][3];
    Vector4_t       m_v[3];
    int             m_busy, m_pix, m_p, m_tri;
    bit             m_ptr, m_owner, exp_start, exp_done, acc;
    bit             w, e_r0, e_r1;
    int             acc_last;
    int             first, errs, dones, viol;
    int             owners[$];

    tbl[0] = '{1'b0, 0, 0, 2, 0, 0, 1, 6};
    tbl[1] = '{1'b1, 5, 5, 5, 5, 5, 5, 1};
    tbl[2] = '{1'b0, 1, 3, 3, 1, 2, 2, 9};
    tbl[3] = '{1'b1, 0, 0, 3, 3, 1, 2, 16};
    tbl[4] = '{1'b1, 7, 2, 7, 4, 7, 3, 3};

    // Outputs during reset, with a requester offering.
    i_valid0 = 1'b1;
    #1;
    chk("rst_ready0", 128'(o_ready0), 128'd0);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_tri", 128'(o_tri_count), 128'd0);
    i_valid0 = 1'b0;
    do_reset();
    @(negedge i_clk);
    chk("idle_no_ready", 128'({o_ready0, o_ready1}), 128'd0);

    for (int i = 0; i < 5; i++)
      run_one(tbl[i].req, mkv(tbl[i].x1, tbl[i].y1),
              mkv(tbl[i].x2, tbl[i].y2), mkv(tbl[i].x3, tbl[i].y3),
              tbl[i].pix);

    // Reset while the rasterizer is mid-triangle.
    offer(1'b0, mkv(1, 1), mkv(4, 4), mkv(1, 4));
    repeat (6) @(negedge i_clk);
    chk("mid_busy", 128'(o_busy), 128'd1);
    i_reset_n = 1'b0;
    i_valid0 = 1'b1;
    #1;
    chk("mr_ready0", 128'(o_ready0), 128'd0);
    chk("mr_flags", 128'({o_busy, o_start, o_done, o_error, o_owner}),
        128'd0);
    chk("mr_verts", 128'({o_v1, o_v2, o_v3}), 128'd0);
    chk("mr_pix", 128'(o_pixel_count), 128'd0);
    chk("mr_tri", 128'(o_tri_count), 128'd0);
    repeat (2) @(negedge i_clk);
    chk("mr_hold_ready", 128'(o_ready0), 128'd0);
    i_valid0 = 1'b0;
    i_reset_n = 1'b1;
    exp_tri = 0;
    run_one(1'b0, mkv(0, 0), mkv(2, 0), mkv(0, 1), 6);

    // Contention: both requesters offer continuously.
    do_reset();
    set_req(1'b0, mkv(0, 0), mkv(1, 0), mkv(0, 0), 1'b1);
    set_req(1'b1, mkv(2, 2), mkv(2, 4), mkv(2, 3), 1'b1);
    viol = 0;
    owners = {};
    for (int k = 0; k < 200 && owners.size() < 4; k++) begin
      @(negedge i_clk);
      if (o_busy && (o_ready0 || o_ready1)) viol++;
      if (o_done) owners.push_back(int'(o_owner));
    end
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    chk("cont_n", 128'(owners.size()), 128'd4);
    for (int k = 0; k < owners.size(); k++)
      chk("cont_owner", 128'(owners[k]), 128'(k % 2));
    chk("cont_tri", 128'(o_tri_count), 128'd4);
    chk("cont_ready_busy", 128'(viol), 128'd0);
    repeat (10) @(negedge i_clk);

    // Timeout: rasterizer never leaves idle.
    do_reset();
    rast_en = 1'b0;
    offer(1'b0, mkv(0, 0), mkv(2, 2), mkv(1, 1));
    @(negedge i_clk);
    chk("tmo_start", 128'(o_start), 128'd1);
    first = -1;
    errs = 0;
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_clk);
      if (o_error) begin
        errs++;
        if (first < 0) first = k;
      end
      if (o_done) dones++;
    end
    chk("tmo_lat", 128'(first), 128'(TMO + 1));
    chk("tmo_once", 128'(errs), 128'd1);
    chk("tmo_nodone", 128'(dones), 128'd0);
    chk("tmo_tri", 128'(o_tri_count), 128'd0);
    chk("tmo_idle", 128'(o_busy), 128'd0);
    rast_en = 1'b1;

    // Randomized traffic against a transaction-level model.
    do_reset();
    off_valid = '{1'b0, 1'b0};
    m_v = '{default: '0};
    m_busy = 0; m_pix = 0; m_p = 0; m_tri = 0;
    m_ptr = 1'b0; m_owner = 1'b0;
    exp_start = 1'b0; exp_done = 1'b0;
    acc_last = -1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge i_clk);
      chk("r_busy", 128'(o_busy), 128'(m_busy > 0));
      chk("r_start", 128'(o_start), 128'(exp_start));
      chk("r_done", 128'(o_done), 128'(exp_done));
      chk("r_error", 128'(o_error), 128'd0);
      chk("r_tri", 128'(o_tri_count), 128'(m_tri));
      chk("r_pix", 128'(o_pixel_count), 128'(m_pix));
      chk("r_owner", 128'(o_owner), 128'(m_owner));
      chk("r_verts", 128'({o_v1, o_v2, o_v3}), 128'({m_v[0], m_v[1], m_v[2]}));
      for (int r = 0; r < 2; r++) begin
        if (acc_last == r) off_valid[r] = 1'b0;
        if (!off_valid[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            off_valid[r] = 1'b1;
            for (int j = 0; j < 3; j++) begin
              off_v[r][j].x = 32'($urandom_range(0, 3));
              off_v[r][j].y = 32'($urandom_range(0, 3));
              off_v[r][j].z = $urandom;
              off_v[r][j].w = $urandom;
            end
          end
        end else if ($urandom_range(0, 9) == 0) begin
          off_valid[r] = 1'b0;
        end
        set_req(r[0], off_v[r][0], off_v[r][1], off_v[r][2], off_valid[r]);
      end
      #1;
      acc = 1'b0;
      w = 1'b0;
      if (m_busy == 0 && (off_valid[0] || off_valid[1])) begin
        acc = 1'b1;
        if (off_valid[0] && off_valid[1]) w = m_ptr;
        else w = off_valid[1];
      end
      e_r0 = acc && !w;
      e_r1 = acc && w;
      chk("r_ready0", 128'(o_ready0), 128'(e_r0));
      chk("r_ready1", 128'(o_ready1), 128'(e_r1));
      @(posedge i_clk);
      exp_start = 1'b0;
      exp_done = 1'b0;
      acc_last = -1;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          exp_done = 1'b1;
          m_tri++;
          m_pix = m_p;
        end
      end
      if (acc) begin
        m_p = area(off_v[w][0], off_v[w][1], off_v[w][2]);
        m_busy = m_p + 2;
        m_owner = w;
        m_ptr = ~w;
        m_v[0] = off_v[w][0];
        m_v[1] = off_v[w][1];
        m_v[2] = off_v[w][2];
        exp_start = 1'b1;
        acc_last = int'(w);
      end
    end
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    chk("r_some_traffic", 128'(m_tri > 20), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
